// File: rtl/alarm_pkg.sv
// alarm_pkg: shared definitions for the alarm hub.
// Provides the 2-bit FSM state type, its encodings and a width helper
// used to size counters and the active-channel index (never below 1 bit).
package alarm_pkg;

  localparam int unsigned STATE_W = 2;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t S_DISARMED = 2'd0;
  localparam state_t S_ARMED    = 2'd1;
  localparam state_t S_ENTRY    = 2'd2;
  localparam state_t S_ALARM    = 2'd3;

  // ceil(log2(n)) clamped to a minimum of one bit
  function automatic int unsigned width_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alarm_debounce.sv
// alarm_debounce: one sensor channel front end.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   in   - raw asynchronous sensor level
//   db   - debounced level (registered)
//   rise - one-cycle pulse while db has just gone high
// A 2-flop synchroniser feeds a saturating run-length counter. db is set once
// DEBOUNCE consecutive high samples have been seen and drops on the first low.
module alarm_debounce
  import alarm_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic db,
  output logic rise
);

  localparam int unsigned CW = width_of(DEBOUNCE + 1);

  logic          s1_q, s2_q;
  logic          db_q, db_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (s2_q) begin
      cnt_d = (cnt_q == CW'(DEBOUNCE)) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      cnt_q     <= '0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
    end else begin
      s1_q      <= in;
      s2_q      <= s1_q;
      cnt_q     <= cnt_d;
      db_q      <= (cnt_d == CW'(DEBOUNCE));
      db_prev_q <= db_q;
    end
  end

  assign db   = db_q;
  assign rise = db_q & ~db_prev_q;

endmodule

// File: rtl/alarm_hub.sv
// alarm_hub: multi-channel home-alarm controller.
// Ports:
//   clk       - system clock, rising edge
//   rst       - asynchronous active-high reset
//   sensor    - raw asynchronous sensor levels, 1 = event
//   armed     - arm request level
//   ack       - single-cycle operator acknowledge
//   alarm     - siren drive, high in ALARM
//   latched   - per-channel sticky event flags
//   active_ch - lowest-index set bit of latched, 0 when none
//   state     - FSM state (DISARMED/ARMED/ENTRY/ALARM)
module alarm_hub
  import alarm_pkg::*;
#(
  parameter int unsigned     N_CH         = 4,
  parameter int unsigned     DEBOUNCE     = 3,
  parameter int unsigned     ENTRY_DELAY  = 8,
  parameter logic [N_CH-1:0] ALWAYS_MASK  = N_CH'('b0001),
  parameter logic [N_CH-1:0] DELAYED_MASK = N_CH'('b0100),
  localparam int unsigned    AW           = width_of(N_CH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_CH-1:0]    sensor,
  input  logic               armed,
  input  logic               ack,
  output logic               alarm,
  output logic [N_CH-1:0]    latched,
  output logic [AW-1:0]      active_ch,
  output logic [STATE_W-1:0] state
);

  localparam int unsigned EW = width_of(ENTRY_DELAY);
  // A 24-hour channel is never treated as delayed.
  localparam logic [N_CH-1:0] DEL_EFF = DELAYED_MASK & ~ALWAYS_MASK;

  logic [N_CH-1:0] db_vec, rise_vec;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    alarm_debounce #(
      .DEBOUNCE(DEBOUNCE)
    ) u_db (
      .clk (clk),
      .rst (rst),
      .in  (sensor[g]),
      .db  (db_vec[g]),
      .rise(rise_vec[g])
    );
  end

  state_t          state_q, state_d;
  logic [N_CH-1:0] latched_q, latched_d;
  logic [EW-1:0]   entry_q, entry_d;

  logic            ev_always, ev_nondel, ev_del;
  logic [N_CH-1:0] set_vec, clr_vec;

  assign ev_always = |(rise_vec & ALWAYS_MASK);
  assign ev_nondel = |(rise_vec & ~DEL_EFF);
  assign ev_del    = |(rise_vec & DEL_EFF);

  // While disarmed only 24-hour channels may latch.
  assign set_vec = (state_q == S_DISARMED) ? (rise_vec & ALWAYS_MASK) : rise_vec;
  // Acknowledge releases only channels whose sensor has gone quiet.
  assign clr_vec = ((state_q == S_ALARM) && ack) ? ~db_vec : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_DISARMED;
      latched_q <= '0;
      entry_q   <= '0;
    end else begin
      state_q   <= state_d;
      latched_q <= latched_d;
      entry_q   <= entry_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    latched_d = (latched_q & ~clr_vec) | set_vec;
    entry_d   = entry_q;
    case (state_q)
      S_DISARMED: begin
        if (ev_always) begin
          state_d = S_ALARM;
        end else if (armed) begin
          state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (ev_nondel) begin
          state_d = S_ALARM;
        end else if (ev_del) begin
          state_d = S_ENTRY;
          entry_d = EW'(ENTRY_DELAY - 1);
        end else if (!armed) begin
          state_d = S_DISARMED;
        end
      end
      S_ENTRY: begin
        if (ev_nondel) begin
          state_d = S_ALARM;
        end else if (!armed) begin
          state_d   = S_DISARMED;
          latched_d = '0;
        end else if (entry_q == '0) begin
          state_d = S_ALARM;
        end else begin
          entry_d = entry_q - 1'b1;
        end
      end
      S_ALARM: begin
        // A coincident event keeps its flag set, which holds ALARM.
        if (ack && (latched_d == '0)) begin
          state_d = armed ? S_ARMED : S_DISARMED;
        end
      end
      default: state_d = S_DISARMED;
    endcase
  end

  always_comb begin
    alarm     = (state_q == S_ALARM);
    active_ch = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (latched_q[i]) begin
        active_ch = AW'(i);
      end
    end
  end

  assign latched = latched_q;
  assign state   = state_q;

endmodule

// File: tb/tb_alarm_hub.sv
module tb_alarm_hub;

  localparam int         D  = 3;
  localparam int         ED = 8;
  localparam logic [3:0] AM = 4'b0001;
  localparam logic [3:0] DM = 4'b0100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       armed = 1'b0;
  logic       ack = 1'b0;
  logic [3:0] sensor = 4'b0;
  logic       alarm;
  logic [3:0] latched;
  logic [1:0] active_ch;
  logic [1:0] state;

  alarm_hub #(
    .N_CH        (4),
    .DEBOUNCE    (D),
    .ENTRY_DELAY (ED),
    .ALWAYS_MASK (AM),
    .DELAYED_MASK(DM)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sensor   (sensor),
    .armed    (armed),
    .ack      (ack),
    .alarm    (alarm),
    .latched  (latched),
    .active_ch(active_ch),
    .state    (state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: per channel, run[k] = number of consecutive edges up to k
  // at which the sensor was sampled high. The debounced level after edge k is
  // run[k-2] >= D; an event is consumed at edge k when db(k-1) & !db(k-2).
  int         hist[4][4];  // hist[i][j] = run at edge (t - j)
  int         m_st;        // 0 disarmed, 1 armed, 2 entry, 3 alarm
  logic [3:0] m_lat;
  int         deadline;
  int         t = 0;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) hist[i][j] = 0;
    m_st  = 0;
    m_lat = 4'b0;
  endtask

  task automatic step();
    logic [3:0] ev, dbv, set, dl;
    bit         alw, nondel, del;
    @(posedge clk);
    t++;
    if (rst) begin
      model_reset();
    end else begin
      dl = DM & ~AM;
      for (int i = 0; i < 4; i++) begin
        dbv[i] = (hist[i][2] >= D);
        ev[i]  = dbv[i] && (hist[i][3] < D);
        hist[i][3] = hist[i][2];
        hist[i][2] = hist[i][1];
        hist[i][1] = hist[i][0];
        hist[i][0] = sensor[i] ? ((hist[i][1] < 100) ? hist[i][1] + 1 : 100) : 0;
      end
      alw    = |(ev & AM);
      nondel = |(ev & ~dl);
      del    = |(ev & dl);
      set    = (m_st == 0) ? (ev & AM) : ev;
      case (m_st)
        0: begin
          m_lat |= set;
          if (alw) m_st = 3;
          else if (armed) m_st = 1;
        end
        1: begin
          m_lat |= set;
          if (nondel) m_st = 3;
          else if (del) begin m_st = 2; deadline = t + ED; end
          else if (!armed) m_st = 0;
        end
        2: begin
          m_lat |= set;
          if (nondel) m_st = 3;
          else if (!armed) begin m_st = 0; m_lat = 4'b0; end
          else if (t == deadline) m_st = 3;
        end
        default: begin
          if (ack) m_lat &= dbv;
          m_lat |= set;
          if (ack && m_lat == 4'b0) m_st = armed ? 1 : 0;
        end
      endcase
    end
    #1;
  endtask

  function automatic logic [8:0] dut_v();
    return {state, alarm, latched, active_ch};
  endfunction

  function automatic logic [8:0] mdl_v();
    logic [1:0] a = 2'd0;
    logic [1:0] s = m_st[1:0];
    for (int i = 3; i >= 0; i--) if (m_lat[i]) a = i[1:0];
    return {s, (m_st == 3), m_lat, a};
  endfunction

  task automatic clear_alarm(input logic arm_after);
    sensor = 4'b0;
    repeat (5) begin
      step(); checks++;
      if (dut_v() !== mdl_v()) begin
        failures++; $display("FAIL clear_settle t=%0d got=%h exp=%h", t, dut_v(), mdl_v());
      end
    end
    ack = 1'b1; armed = arm_after;
    step(); ack = 1'b0;
    checks++;
    if (state !== {1'b0, arm_after} || latched !== 4'b0) begin
      failures++;
      $display("FAIL clear_ack got state=%0d latched=%b exp state=%0d latched=0000",
               state, latched, arm_after);
    end
  endtask

  task automatic test_reset();
    #2; checks++;
    if (dut_v() !== 9'd0) begin
      failures++; $display("FAIL reset_values got=%h exp=000", dut_v());
    end
    model_reset();
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic test_disarmed_ignore();
    armed = 1'b0; sensor = 4'b0010;
    repeat (10) begin
      step(); checks++;
      if (dut_v() !== mdl_v()) begin
        failures++; $display("FAIL ignore_model t=%0d got=%h exp=%h", t, dut_v(), mdl_v());
      end
    end
    checks++;
    if (latched !== 4'b0 || alarm !== 1'b0) begin
      failures++; $display("FAIL ignore_disarmed got latched=%b alarm=%b exp 0000/0", latched, alarm);
    end
    sensor = 4'b0001;
    repeat (6) step();
    checks++;
    if (latched !== 4'b0001 || alarm !== 1'b1 || state !== 2'd3) begin
      failures++;
      $display("FAIL always_chan got latched=%b alarm=%b state=%0d exp 0001/1/3",
               latched, alarm, state);
    end
    clear_alarm(1'b0);
  endtask

  task automatic test_pulse();
    armed = 1'b1;
    step();
    sensor = 4'b1000;
    repeat (2) step();
    sensor = 4'b0;
    repeat (8) step();
    checks++;
    if (state !== 2'd1 || latched !== 4'b0) begin
      failures++; $display("FAIL short_pulse got state=%0d latched=%b exp 1/0000", state, latched);
    end
    sensor = 4'b1000;
    repeat (5) begin
      step(); checks++;
      if (alarm !== 1'b0) begin
        failures++; $display("FAIL pulse_early got alarm=%b exp 0 t=%0d", alarm, t);
      end
    end
    sensor = 4'b0;
    step(); checks++;
    if (alarm !== 1'b1 || active_ch !== 2'd3) begin
      failures++; $display("FAIL long_pulse got alarm=%b active_ch=%0d exp 1/3", alarm, active_ch);
    end
    clear_alarm(1'b1);
  endtask

  task automatic test_entry();
    bit seen;
    armed = 1'b1; sensor = 4'b0100;
    repeat (6) step();
    checks++;
    if (state !== 2'd2) begin
      failures++; $display("FAIL entry_start got state=%0d exp 2", state);
    end
    repeat (7) begin
      step(); checks++;
      if (alarm !== 1'b0) begin
        failures++; $display("FAIL entry_early got alarm=%b exp 0 t=%0d", alarm, t);
      end
    end
    step(); checks++;
    if (alarm !== 1'b1) begin
      failures++; $display("FAIL entry_timeout got alarm=%b exp 1", alarm);
    end
    clear_alarm(1'b1);
    sensor = 4'b0100;
    repeat (6) step();
    checks++;
    if (state !== 2'd2) begin
      failures++; $display("FAIL entry_again got state=%0d exp 2", state);
    end
    seen = 1'b0;
    repeat (3) begin step(); seen |= alarm; end
    armed = 1'b0;
    step();
    checks++;
    if (state !== 2'd0 || latched !== 4'b0) begin
      failures++; $display("FAIL entry_disarm got state=%0d latched=%b exp 0/0000", state, latched);
    end
    repeat (6) begin step(); seen |= alarm; end
    checks++;
    if (seen !== 1'b0) begin
      failures++; $display("FAIL entry_no_alarm got alarm seen=%b exp 0", seen);
    end
    sensor = 4'b0;
    repeat (5) step();
  endtask

  task automatic test_ack_hold();
    armed = 1'b1; step();
    sensor = 4'b1000;
    repeat (6) step();
    ack = 1'b1; step(); ack = 1'b0;
    checks++;
    if (latched !== 4'b1000 || state !== 2'd3) begin
      failures++; $display("FAIL ack_held got latched=%b state=%0d exp 1000/3", latched, state);
    end
    clear_alarm(1'b1);
    checks++;
    if (alarm !== 1'b0) begin
      failures++; $display("FAIL ack_release got alarm=%b exp 0", alarm);
    end
  endtask

  task automatic test_ack_event();
    armed = 1'b1;
    sensor = 4'b1000;
    repeat (6) step();
    sensor = 4'b1010;
    repeat (5) step();
    ack = 1'b1; step(); ack = 1'b0;
    checks++;
    if (latched !== 4'b1010 || state !== 2'd3 || active_ch !== 2'd1) begin
      failures++;
      $display("FAIL ack_event got latched=%b state=%0d active_ch=%0d exp 1010/3/1",
               latched, state, active_ch);
    end
    clear_alarm(1'b1);
  endtask

  task automatic test_reset_mid();
    armed = 1'b1; sensor = 4'b0100;
    repeat (8) step();
    checks++;
    if (state !== 2'd2) begin
      failures++; $display("FAIL rst_pre got state=%0d exp 2", state);
    end
    rst = 1'b1; #1;
    checks++;
    if (dut_v() !== 9'd0) begin
      failures++; $display("FAIL rst_async got=%h exp=000", dut_v());
    end
    model_reset();
    repeat (2) step();
    rst = 1'b0; armed = 1'b0;
    repeat (10) begin
      step(); checks++;
      if (dut_v() !== mdl_v()) begin
        failures++; $display("FAIL rst_after t=%0d got=%h exp=%h", t, dut_v(), mdl_v());
      end
    end
    checks++;
    if (state !== 2'd0 || latched !== 4'b0) begin
      failures++; $display("FAIL rst_release got state=%0d latched=%b exp 0/0000", state, latched);
    end
    sensor = 4'b0;
    repeat (5) step();
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++) if ($urandom_range(7) == 0) sensor[i] = ~sensor[i];
      if ($urandom_range(24) == 0) armed = ~armed;
      ack = ($urandom_range(6) == 0);
      if (rst) rst = 1'b0;
      else if ($urandom_range(599) == 0) begin rst = 1'b1; #1; model_reset(); end
      step(); checks++;
      if (dut_v() !== mdl_v()) begin
        failures++; $display("FAIL random t=%0d got=%h exp=%h", t, dut_v(), mdl_v());
      end
    end
    ack = 1'b0; rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_disarmed_ignore();
    test_pulse();
    test_entry();
    test_ack_hold();
    test_ack_event();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
